x_mem_arb: RTL and testbench
============================

X_MEM_ARB -- requirements
Module: x_mem_arb

Interface
REQ-001 SHALL have port i_clk  input  1  single clock; all state on posedge.
REQ-002 SHALL have port i_rst  input  1  asynchronous reset, active-high.
REQ-003 SHALL have ports i_m0_valid/i_m0_rnw  input  1/1  master 0 (core) request, read-not-write.
REQ-004 SHALL have ports i_m0_addr/i_m0_data  input  32/32  master 0 address, write data.
REQ-005 SHALL have port o_m0_accept  output  1  master 0 transfer completes this cycle.
REQ-006 SHALL have ports i_m1_valid/i_m1_rnw/i_m1_addr/i_m1_data  input  1/1/32/32  master 1 (debug/loader) request, same meaning as master 0.
REQ-007 SHALL have port o_m1_accept  output  1  master 1 transfer completes this cycle.
REQ-008 SHALL have port o_rdata  output  32  read data, broadcast to both masters.
REQ-009 SHALL have ports o_mem_valid/o_mem_rnw/o_mem_addr/o_mem_data  output  1/1/32/32  shared memory request.
REQ-010 SHALL have ports i_mem_accept/i_mem_data  input  1/32  memory completion, read data.
REQ-011 SHALL have port o_busy  output  1  a grant is held.

Function
REQ-012 SHALL use the request protocol: a master holds valid/rnw/addr/data stable until accept; read data is valid in the accept cycle.
REQ-013 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-014 IDLE: SHALL go to GNT0 or GNT1 on the next edge when a request is present, chosen per REQ-021/022; SHALL stay in IDLE with no request.
REQ-015 GNTx: SHALL drive o_mem_* from master x combinationally with o_mem_valid = i_mx_valid; SHALL set o_mx_accept = i_mem_accept; the other accept SHALL be 0.
REQ-016 GNTx with i_mem_accept=1: SHALL return to IDLE; every transfer therefore takes at least 2 cycles (1 arbitration + ≥1 memory).
REQ-017 GNTx with i_mx_valid dropped before accept: SHALL return to IDLE with no accept issued (abandon).
REQ-018 In IDLE, o_mem_valid, both accepts and o_busy SHALL be 0; o_mem_addr/o_mem_data/o_mem_rnw SHALL be 0.
REQ-019 o_rdata SHALL equal i_mem_data in every cycle (pass-through).
REQ-020 SHALL keep a 4-bit saturating counter of consecutive m0 grants made while m1 was requesting; it clears on any m1 grant.
REQ-021 Fixed priority: m0 wins over m1 unless the starvation counter equals 15, in which case m1 wins the next arbitration.
REQ-022 Both valid in the same IDLE cycle SHALL resolve per REQ-021 (or REQ-027); a single requester always wins.

Reset
REQ-023 i_rst=1 SHALL force IDLE, starvation counter 0 and RR pointer 0 asynchronously; all outputs SHALL become 0 with no clock edge.
REQ-024 Reset asserted mid-grant SHALL abandon the transfer; no accept SHALL be issued during or on the first cycle after reset.

Configuration
REQ-025 Macro X_MEM_ARB_RR_EN SHALL select round-robin arbitration.
REQ-026 Without it: fixed priority with starvation counter per REQ-020/021.
REQ-027 With it: a 1-bit pointer names the preferred master; it flips to the other master after each completed (accepted) grant; the starvation counter is not present.

Structure
REQ-028 Package x_mem_arb_pkg SHALL hold the state enum (IDLE, GNT0, GNT1), the request struct {valid, rnw, addr[31:0], data[31:0]} and the constant STARVE_MAX=15.
REQ-029 Sub-module x_mem_arb_pick SHALL hold the combinational grant choice (requests, counter/pointer -> winner); the FSM and counters SHALL remain in x_mem_arb.

Verification
REQ-030 Apply m0 read of 0x100 only, memory accepts after 3 cycles with i_mem_data=0xDEADBEEF -> o_mem_valid rises 1 cycle after request; o_m0_accept pulses once; o_rdata=0xDEADBEEF.
REQ-031 Assert m0 and m1 valid in the same cycle, memory accepts immediately (fixed priority build) -> order is m0, m1; each access takes 2 cycles.
REQ-032 Hold m0 continuously with m1 valid (fixed priority build) -> 15 consecutive m0 grants, then one m1 grant, then the counter clears.
REQ-033 Both masters request continuously (X_MEM_ARB_RR_EN build) -> grants alternate m0, m1, m0, m1 starting with m0 after reset.
REQ-034 m1 write 0x5A to 0x20, reset asserted in the GNT1 cycle before accept -> all outputs 0 immediately; no o_m1_accept; FSM in IDLE after release.
REQ-035 m0 granted, i_m0_valid drops before i_mem_accept -> FSM returns to IDLE; no accept; pending m1 granted next.

Source files
------------

// File: rtl/x_mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// X_MEM_ARB_RR_EN selects round-robin instead of fixed priority with starvation guard.
package x_mem_arb_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_W   = 4;
    localparam int STARVE_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              valid;
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // True once master 0 has been favoured often enough that master 1 must win next.
    function automatic logic starve_sat(input logic [STARVE_W-1:0] cnt);
        return cnt == STARVE_W'(STARVE_MAX);
    endfunction

endpackage

// File: rtl/x_mem_arb_pick.sv
// Combinational winner selection for one arbitration cycle.
// With X_MEM_ARB_RR_EN the preference comes from the round-robin pointer, else from the starvation count.
module x_mem_arb_pick
    import x_mem_arb_pkg::*;
(
    input  logic                m0_valid_i,
    input  logic                m1_valid_i,
`ifdef X_MEM_ARB_RR_EN
    input  logic                ptr_i,
`else
    input  logic [STARVE_W-1:0] starve_i,
`endif
    output logic                gnt_any_o,
    output logic                gnt_m1_o
);

    logic prefer_m1;

`ifdef X_MEM_ARB_RR_EN
    assign prefer_m1 = ptr_i;
`else
    assign prefer_m1 = starve_sat(starve_i);
`endif

    // A lone requester always wins; preference only matters on a tie.
    always_comb begin
        gnt_any_o = m0_valid_i | m1_valid_i;
        gnt_m1_o  = m1_valid_i & (~m0_valid_i | prefer_m1);
    end

endmodule

// File: rtl/x_mem_arb.sv
// Two-master (core, debug/loader) arbiter in front of one shared memory port.
// Define X_MEM_ARB_RR_EN for round-robin; default is fixed priority with a starvation counter.
module x_mem_arb
    import x_mem_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_m0_valid,
    input  logic              i_m0_rnw,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    output logic              o_m0_accept,

    input  logic              i_m1_valid,
    input  logic              i_m1_rnw,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data,
    output logic              o_m1_accept,

    output logic [DATA_W-1:0] o_rdata,

    output logic              o_mem_valid,
    output logic              o_mem_rnw,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic              i_mem_accept,
    input  logic [DATA_W-1:0] i_mem_data,

    output logic              o_busy
);

    arb_state_e state_q, state_d;
`ifdef X_MEM_ARB_RR_EN
    logic ptr_q, ptr_d;
`else
    logic [STARVE_W-1:0] starve_q, starve_d;
`endif

    mem_req_t m0_req, m1_req, mem_req;
    logic     m0_accept, m1_accept, busy;
    logic     gnt_any, gnt_m1;

    assign m0_req = '{valid: i_m0_valid, rnw: i_m0_rnw, addr: i_m0_addr, data: i_m0_data};
    assign m1_req = '{valid: i_m1_valid, rnw: i_m1_rnw, addr: i_m1_addr, data: i_m1_data};

    x_mem_arb_pick u_pick (
        .m0_valid_i (i_m0_valid),
        .m1_valid_i (i_m1_valid),
`ifdef X_MEM_ARB_RR_EN
        .ptr_i      (ptr_q),
`else
        .starve_i   (starve_q),
`endif
        .gnt_any_o  (gnt_any),
        .gnt_m1_o   (gnt_m1)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
`ifdef X_MEM_ARB_RR_EN
            ptr_q    <= 1'b0;
`else
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
`ifdef X_MEM_ARB_RR_EN
            ptr_q    <= ptr_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    // A grant ends on completion or when its master withdraws the request.
    always_comb begin
        state_d = state_q;
`ifdef X_MEM_ARB_RR_EN
        ptr_d = ptr_q;
`else
        starve_d = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = gnt_m1 ? GNT1 : GNT0;
`ifndef X_MEM_ARB_RR_EN
                    if (gnt_m1) begin
                        starve_d = '0;
                    end else if (i_m1_valid && !starve_sat(starve_q)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
`endif
                end
            end
            GNT0: begin
                if (i_mem_accept || !i_m0_valid) begin
                    state_d = IDLE;
                end
`ifdef X_MEM_ARB_RR_EN
                if (i_mem_accept) begin
                    ptr_d = 1'b1;
                end
`endif
            end
            GNT1: begin
                if (i_mem_accept || !i_m1_valid) begin
                    state_d = IDLE;
                end
`ifdef X_MEM_ARB_RR_EN
                if (i_mem_accept) begin
                    ptr_d = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req   = '0;
        m0_accept = 1'b0;
        m1_accept = 1'b0;
        busy      = 1'b0;
        case (state_q)
            GNT0: begin
                mem_req   = m0_req;
                m0_accept = i_mem_accept;
                busy      = 1'b1;
            end
            GNT1: begin
                mem_req   = m1_req;
                m1_accept = i_mem_accept;
                busy      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_mem_valid = mem_req.valid;
    assign o_mem_rnw   = mem_req.rnw;
    assign o_mem_addr  = mem_req.addr;
    assign o_mem_data  = mem_req.data;
    assign o_m0_accept = m0_accept;
    assign o_m1_accept = m1_accept;
    assign o_busy      = busy;

    // Read data is a straight pass-through, forced quiet while reset is held.
    assign o_rdata = i_rst ? '0 : i_mem_data;

endmodule

// File: tb/tb_x_mem_arb.sv
// Directed testbench for x_mem_arb; expected values are hand-computed per step.
// Runs the round-robin scenario when X_MEM_ARB_RR_EN is defined, the starvation scenario otherwise.
module tb_x_mem_arb;

    logic        clk;
    logic        rst;
    logic        m0Valid, m0Rnw, m1Valid, m1Rnw;
    logic [31:0] m0Addr, m0Data, m1Addr, m1Data;
    logic        m0Accept, m1Accept;
    logic [31:0] rdata;
    logic        memValid, memRnw;
    logic [31:0] memAddr, memDataOut;
    logic        memAccept;
    logic [31:0] memDataIn;
    logic        busy;

    int vectors;
    int miscompares;

    x_mem_arb dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_m0_valid   (m0Valid),
        .i_m0_rnw     (m0Rnw),
        .i_m0_addr    (m0Addr),
        .i_m0_data    (m0Data),
        .o_m0_accept  (m0Accept),
        .i_m1_valid   (m1Valid),
        .i_m1_rnw     (m1Rnw),
        .i_m1_addr    (m1Addr),
        .i_m1_data    (m1Data),
        .o_m1_accept  (m1Accept),
        .o_rdata      (rdata),
        .o_mem_valid  (memValid),
        .o_mem_rnw    (memRnw),
        .o_mem_addr   (memAddr),
        .o_mem_data   (memDataOut),
        .i_mem_accept (memAccept),
        .i_mem_data   (memDataIn),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive all request inputs at the falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic v0, input logic r0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic r1, input logic [31:0] a1, input logic [31:0] d1,
                                 input logic acc, input logic [31:0] md);
        @(negedge clk);
        m0Valid = v0; m0Rnw = r0; m0Addr = a0; m0Data = d0;
        m1Valid = v1; m1Rnw = r1; m1Addr = a1; m1Data = d1;
        memAccept = acc; memDataIn = md;
        #1;
    endtask

    task automatic waitStep();
        @(negedge clk);
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        m0Valid = 0; m0Rnw = 0; m0Addr = 0; m0Data = 0;
        m1Valid = 0; m1Rnw = 0; m1Addr = 0; m1Data = 0;
        memAccept = 0; memDataIn = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        m0Valid = 0; m0Rnw = 0; m0Addr = 0; m0Data = 0;
        m1Valid = 0; m1Rnw = 0; m1Addr = 0; m1Data = 0;
        memAccept = 0; memDataIn = 0;
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mem_valid", {31'd0, memValid}, 32'd0);
        checkOutput("rst_accepts", {30'd0, m1Accept, m0Accept}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // m0 read of 0x100, memory answers on the third grant cycle
        applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_idle_valid", {31'd0, memValid}, 32'd0);
        waitStep();
        checkOutput("rd_gnt_valid", {31'd0, memValid}, 32'd1);
        checkOutput("rd_gnt_addr", memAddr, 32'h100);
        checkOutput("rd_gnt_rnw", {31'd0, memRnw}, 32'd1);
        checkOutput("rd_gnt_busy", {31'd0, busy}, 32'd1);
        checkOutput("rd_wait1_acc", {30'd0, m1Accept, m0Accept}, 32'd0);
        waitStep();
        checkOutput("rd_wait2_acc", {30'd0, m1Accept, m0Accept}, 32'd0);
        applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        checkOutput("rd_accept", {30'd0, m1Accept, m0Accept}, 32'd1);
        checkOutput("rd_rdata", rdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);
        checkOutput("rd_after_acc", {30'd0, m1Accept, m0Accept}, 32'd0);
        checkOutput("rd_after_busy", {31'd0, busy}, 32'd0);
        checkOutput("rd_after_addr", memAddr, 32'd0);
        checkOutput("rd_rdata_pass", rdata, 32'h0BADF00D);

        // simultaneous requests, memory always ready: m0 first, then m1
        applyReset();
        applyStimulus(1, 0, 32'h40, 32'h11, 1, 1, 32'h80, 0, 1, 0);
        checkOutput("both_idle_acc", {30'd0, m1Accept, m0Accept}, 32'd0);
        checkOutput("both_idle_busy", {31'd0, busy}, 32'd0);
        waitStep();
        checkOutput("both_g0_acc", {30'd0, m1Accept, m0Accept}, 32'd1);
        checkOutput("both_g0_addr", memAddr, 32'h40);
        checkOutput("both_g0_data", memDataOut, 32'h11);
        checkOutput("both_g0_rnw", {31'd0, memRnw}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h80, 0, 1, 0);
        checkOutput("both_idle2_busy", {31'd0, busy}, 32'd0);
        waitStep();
        checkOutput("both_g1_acc", {30'd0, m1Accept, m0Accept}, 32'd2);
        checkOutput("both_g1_addr", memAddr, 32'h80);
        checkOutput("both_g1_rnw", {31'd0, memRnw}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("both_end_busy", {31'd0, busy}, 32'd0);

`ifdef X_MEM_ARB_RR_EN
        // both masters always requesting: strict alternation from m0
        applyReset();
        applyStimulus(1, 1, 32'hA0, 0, 1, 1, 32'hB0, 0, 1, 0);
        for (int g = 0; g < 6; g++) begin
            waitStep();
            checkOutput($sformatf("rr_grant%0d", g), {30'd0, m1Accept, m0Accept},
                        (g % 2 == 0) ? 32'd1 : 32'd2);
            waitStep();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
        // m0 hogging while m1 waits: 15 m0 grants, one m1 grant, and again
        applyReset();
        applyStimulus(1, 1, 32'hA0, 0, 1, 1, 32'hB0, 0, 1, 0);
        for (int r = 0; r < 2; r++) begin
            for (int g = 0; g < 16; g++) begin
                waitStep();
                checkOutput($sformatf("starve_r%0d_g%0d", r, g), {30'd0, m1Accept, m0Accept},
                            (g == 15) ? 32'd2 : 32'd1);
                if (g == 15) begin
                    checkOutput($sformatf("starve_r%0d_m1addr", r), memAddr, 32'hB0);
                end
                waitStep();
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        // reset asserted mid-grant of an m1 write
        applyReset();
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h20, 32'h5A, 0, 0);
        waitStep();
        checkOutput("rstmid_addr", memAddr, 32'h20);
        checkOutput("rstmid_data", memDataOut, 32'h5A);
        checkOutput("rstmid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        memAccept = 1'b1;
        memDataIn = 32'h12345678;
        #1;
        checkOutput("rstmid_valid0", {31'd0, memValid}, 32'd0);
        checkOutput("rstmid_addr0", memAddr, 32'd0);
        checkOutput("rstmid_data0", memDataOut, 32'd0);
        checkOutput("rstmid_busy0", {31'd0, busy}, 32'd0);
        checkOutput("rstmid_acc0", {30'd0, m1Accept, m0Accept}, 32'd0);
        checkOutput("rstmid_rdata0", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m1Valid = 1'b0;
        #1;
        checkOutput("rstrel_acc", {30'd0, m1Accept, m0Accept}, 32'd0);
        checkOutput("rstrel_busy", {31'd0, busy}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstrel_idle", {31'd0, busy}, 32'd0);

        // m0 abandons its grant; pending m1 takes over
        applyReset();
        applyStimulus(1, 1, 32'h300, 0, 1, 1, 32'h400, 0, 0, 0);
        waitStep();
        checkOutput("abn_g0_addr", memAddr, 32'h300);
        checkOutput("abn_g0_busy", {31'd0, busy}, 32'd1);
        applyStimulus(0, 1, 32'h300, 0, 1, 1, 32'h400, 0, 0, 0);
        checkOutput("abn_drop_valid", {31'd0, memValid}, 32'd0);
        checkOutput("abn_drop_acc", {30'd0, m1Accept, m0Accept}, 32'd0);
        waitStep();
        checkOutput("abn_idle_busy", {31'd0, busy}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h400, 0, 1, 32'hCAFE0001);
        checkOutput("abn_g1_addr", memAddr, 32'h400);
        checkOutput("abn_g1_acc", {30'd0, m1Accept, m0Accept}, 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("abn_end_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
